data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the arm_cpu data-memory interface: services mem_rd/mem_wr
//  requests issued by the core against an internal word RAM plus a memory-mapped
//  I/O register at 16'hFFFF. Adds configurable read wait-states and stalls the
//  core through mem_ready. Sits between arm_cpu and the board-level I/O pins.
// PARAMETERS
//  BITS     16  data/address width in bits
//  AW       8   RAM index width; RAM depth = 2**AW words, word-addressed
//  RD_LAT   2   read latency in clock edges (must be >= 1)
// PORTS
//  clk           in   1     system clock, rising edge
//  rst           in   1     asynchronous, active-high reset
//  mem_addr      in   BITS  word address from core
//  mem_data      in   BITS  write data from core
//  mem_rd        in   1     read request, level, sampled at posedge
//  mem_wr        in   1     write request, level, sampled at posedge
//  mem_data_out  out  BITS  read data to core
//  mem_ready     out  1     1 = responder idle and accepting; 0 = core must stall
//  mem_err       out  1     one-cycle pulse: illegal access detected
//  io_in         in   BITS  external input, returned on read of 16'hFFFF
//  io_out        out  BITS  external output register, written via 16'hFFFF
//  io_valid      out  1     one-cycle pulse after io_out is updated
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, mem_data_out=0, mem_ready=1, mem_err=0,
//   io_out=0, io_valid=0, wait counter=0. RAM contents are not cleared.
//  FSM: IDLE, WAIT. Requests are sampled only in IDLE; in WAIT, all request
//   inputs are ignored. The core holds them stable while mem_ready=0.
//  Address decode: 16'hFFFF selects IO. addr < 2**AW selects RAM[addr[AW-1:0]].
//   Any other address is unmapped.
//  Write (IDLE, mem_wr=1, mem_rd=0), sampled at edge N:
//   - RAM: word is written at edge N. Zero wait states; mem_ready stays 1.
//   - IO: io_out<=mem_data at edge N; io_valid=1 for the cycle after edge N.
//   - Unmapped: no state change; mem_err pulses for the cycle after edge N.
//  Read (IDLE, mem_rd=1, mem_wr=0), sampled at edge N:
//   - Address is latched. Data is taken from RAM, io_in (captured at edge N),
//     or 0 if unmapped (unmapped also pulses mem_err).
//   - RD_LAT=1: mem_data_out updates at edge N; FSM stays IDLE; no stall.
//   - RD_LAT>1: at edge N, go to WAIT, mem_ready<=0, cnt<=RD_LAT-1. cnt
//     decrements each edge. At the edge where cnt==1: mem_data_out updates,
//     mem_ready<=1, return to IDLE. mem_ready is low for RD_LAT-1 cycles.
//  mem_data_out holds its last read value until the next read completes;
//   writes never change it.
//  mem_rd and mem_wr both 1 in IDLE: no access; mem_err pulses; stay IDLE.
//  Read-after-write to the same RAM word in consecutive cycles returns the new data.
//  Reset asserted during WAIT: the read is aborted and reset values apply at once.
//  All outputs are registered; there is no combinational path from inputs to outputs.
// CONFIGURATION
//  DMEM_ACCESS_CNT_EN defined: two 16-bit wrapping counters, rd_cnt and wr_cnt.
//   They increment on each accepted, mapped read or write (IO included; error
//   accesses excluded) and reset to 0. They are read-only at 16'hFFFE (rd_cnt)
//   and 16'hFFFD (wr_cnt), with normal read latency. The counter read itself
//   counts after it returns its value. Writes to these addresses are ignored
//   silently (no mem_err).
//  DMEM_ACCESS_CNT_EN undefined: no counters; 16'hFFFE and 16'hFFFD are unmapped.
// TESTING
//  1 Reset: rst=1 mid-stream -> mem_ready=1, mem_data_out=0, io_out=0, io_valid=0 immediately.
//  2 RD_LAT=3: write 16'hBEEF to 16'h0005, then read 16'h0005 -> mem_ready=0 for
//    2 cycles, mem_data_out=16'hBEEF and mem_ready=1 at edge N+2.
//  3 Write 16'h00A5 to 16'hFFFF -> io_out=16'h00A5, io_valid high exactly 1 cycle;
//    io_in=16'h1234, read 16'hFFFF -> mem_data_out=16'h1234.
//  4 AW=8: read 16'h0100 -> mem_data_out=0, mem_err 1 cycle; write 16'h0100 -> RAM
//    unchanged, mem_err 1 cycle.
//  5 mem_rd=mem_wr=1 at 16'h0003 -> mem_err pulse, RAM[3] unchanged,
//    mem_data_out unchanged.
//  6 DMEM_ACCESS_CNT_EN: 3 writes and 2 reads, then read 16'hFFFD -> 3; then read
//    16'hFFFE -> 3 (the 16'hFFFD read counts). Undefined: both reads -> 0 with mem_err.

Source files
------------

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Responder side of the arm_cpu data-memory interface. Serves
//                core reads/writes from an internal word RAM and a memory-
//                mapped I/O register at the all-ones address. Reads take
//                RD_LAT clock edges and stall the core through mem_ready.
//                Optional build macro DMEM_ACCESS_CNT_EN adds read/write
//                access counters, readable at all-ones minus 1 (reads) and
//                all-ones minus 2 (writes).
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int BITS   = 16,
    parameter int AW     = 8,
    parameter int RD_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] mem_addr,
    input  logic [BITS-1:0] mem_data,
    input  logic            mem_rd,
    input  logic            mem_wr,
    output logic [BITS-1:0] mem_data_out,
    output logic            mem_ready,
    output logic            mem_err,
    input  logic [BITS-1:0] io_in,
    output logic [BITS-1:0] io_out,
    output logic            io_valid
);

    // Wait counter only needs to hold RD_LAT-1
    localparam int              c_CW      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [BITS-1:0] c_IO_ADDR = {BITS{1'b1}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [BITS-1:0]   r_rdData;
    logic [BITS-1:0]   r_ram [2**AW];

    logic              w_isRam;
    logic              w_isIo;
    logic              w_isCnt;
    logic              w_mapped;
    logic              w_rdReq;
    logic              w_wrReq;
    logic              w_both;
    logic [BITS-1:0]   w_rdData;

`ifdef DMEM_ACCESS_CNT_EN
    localparam logic [BITS-1:0] c_RDCNT_ADDR = c_IO_ADDR - BITS'(1);
    localparam logic [BITS-1:0] c_WRCNT_ADDR = c_IO_ADDR - BITS'(2);

    logic [15:0] r_rdCnt;
    logic [15:0] r_wrCnt;
    logic        w_isRdCnt;
    logic        w_isWrCnt;

    assign w_isRdCnt = (mem_addr == c_RDCNT_ADDR);
    assign w_isWrCnt = (mem_addr == c_WRCNT_ADDR);
    assign w_isCnt   = w_isRdCnt | w_isWrCnt;
`else
    assign w_isCnt   = 1'b0;
`endif

    assign w_isRam  = ((mem_addr >> AW) == '0);
    assign w_isIo   = (mem_addr == c_IO_ADDR);
    assign w_mapped = w_isRam | w_isIo | w_isCnt;

    // New requests are only recognised while idle
    assign w_rdReq  = (r_state == IDLE) &&  mem_rd && !mem_wr;
    assign w_wrReq  = (r_state == IDLE) && !mem_rd &&  mem_wr;
    assign w_both   = (r_state == IDLE) &&  mem_rd &&  mem_wr;

    // Select the read source for the address presented this cycle
    always_comb begin
        w_rdData = '0;
        if (w_isRam) begin
            w_rdData = r_ram[mem_addr[AW-1:0]];
        end else if (w_isIo) begin
            w_rdData = io_in;
`ifdef DMEM_ACCESS_CNT_EN
        end else if (w_isRdCnt) begin
            w_rdData = BITS'(r_rdCnt);
        end else if (w_isWrCnt) begin
            w_rdData = BITS'(r_wrCnt);
`endif
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && w_wrReq && w_isRam) begin
            r_ram[mem_addr[AW-1:0]] <= mem_data;
        end
    end

    // Request FSM with registered responses; read data is captured at accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_rdData     <= '0;
            mem_data_out <= '0;
            mem_ready    <= 1'b1;
            mem_err      <= 1'b0;
            io_out       <= '0;
            io_valid     <= 1'b0;
        end else begin
            mem_err  <= 1'b0;
            io_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_both) begin
                        mem_err <= 1'b1;
                    end else if (w_wrReq) begin
                        if (w_isIo) begin
                            io_out   <= mem_data;
                            io_valid <= 1'b1;
                        end else if (!w_mapped) begin
                            mem_err <= 1'b1;
                        end
                    end else if (w_rdReq) begin
                        if (!w_mapped) begin
                            mem_err <= 1'b1;
                        end
                        if (RD_LAT == 1) begin
                            mem_data_out <= w_rdData;
                        end else begin
                            r_rdData  <= w_rdData;
                            r_cnt     <= c_CW'(RD_LAT - 1);
                            mem_ready <= 1'b0;
                            r_state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == c_CW'(1)) begin
                        mem_data_out <= r_rdData;
                        mem_ready    <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    // Access counters; a counter read returns the pre-increment value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdCnt <= '0;
            r_wrCnt <= '0;
        end else begin
            if (w_rdReq && w_mapped) begin
                r_rdCnt <= r_rdCnt + 16'd1;
            end
            if (w_wrReq && (w_isRam || w_isIo)) begin
                r_wrCnt <= r_wrCnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Directed self-checking bench for data_mem_responder with
//                RD_LAT=3; expected read data is queued when a read is issued
//                and compared when the responder returns to ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int c_RD_LAT = 3;

    logic        clk;
    logic        rst;
    logic [15:0] memAddr;
    logic [15:0] memData;
    logic        memRd;
    logic        memWr;
    logic [15:0] memDataOut;
    logic        memReady;
    logic        memErr;
    logic [15:0] ioIn;
    logic [15:0] ioOut;
    logic        ioValid;

    int          checks;
    int          errors;
    logic [15:0] scoreQ[$];

    data_mem_responder #(
        .BITS   (16),
        .AW     (8),
        .RD_LAT (c_RD_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (memAddr),
        .mem_data     (memData),
        .mem_rd       (memRd),
        .mem_wr       (memWr),
        .mem_data_out (memDataOut),
        .mem_ready    (memReady),
        .mem_err      (memErr),
        .io_in        (ioIn),
        .io_out       (ioOut),
        .io_valid     (ioValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic doWrite(input logic [15:0] addr, input logic [15:0] data,
                           input logic expErr, input logic expIoValid, input string tag);
        @(negedge clk);
        memAddr = addr;
        memData = data;
        memWr   = 1'b1;
        @(posedge clk); #1;
        memWr = 1'b0;
        check({tag, "_ready"}, 32'(memReady), 32'd1);
        check({tag, "_err"}, 32'(memErr), 32'(expErr));
        check({tag, "_iovalid"}, 32'(ioValid), 32'(expIoValid));
        @(posedge clk); #1;
        check({tag, "_err_pulse_end"}, 32'(memErr), 32'd0);
        check({tag, "_iovalid_pulse_end"}, 32'(ioValid), 32'd0);
    endtask

    task automatic doRead(input logic [15:0] addr, input logic [15:0] expData,
                          input logic expErr, input string tag);
        int          stall;
        bit          first;
        logic [15:0] exp;
        @(negedge clk);
        memAddr = addr;
        memRd   = 1'b1;
        scoreQ.push_back(expData);
        @(posedge clk); #1;
        check({tag, "_err"}, 32'(memErr), 32'(expErr));
        check({tag, "_stall"}, 32'(memReady), 32'd0);
        stall = 1;
        first = 1'b1;
        while (!memReady && stall < 20) begin
            @(posedge clk); #1;
            if (first) begin
                check({tag, "_err_pulse_end"}, 32'(memErr), 32'd0);
                first = 1'b0;
            end
            if (!memReady) stall++;
        end
        memRd = 1'b0;
        check({tag, "_stall_cycles"}, 32'(stall), 32'(c_RD_LAT - 1));
        exp = scoreQ.pop_front();
        check({tag, "_data"}, 32'(memDataOut), 32'(exp));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        memAddr = '0;
        memData = '0;
        memRd   = 1'b0;
        memWr   = 1'b0;
        ioIn    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(memReady), 32'd1);
        check("reset_dataout", 32'(memDataOut), 32'd0);
        check("reset_err", 32'(memErr), 32'd0);
        check("reset_ioout", 32'(ioOut), 32'd0);
        check("reset_iovalid", 32'(ioValid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // RAM write then immediate read, 2-cycle stall
        doWrite(16'h0005, 16'hBEEF, 1'b0, 1'b0, "wr_ram5");
        doRead (16'h0005, 16'hBEEF, 1'b0, "rd_ram5");

        // IO register write and io_in readback
        doWrite(16'hFFFF, 16'h00A5, 1'b0, 1'b1, "wr_io");
        check("io_out_value", 32'(ioOut), 32'h00A5);
        ioIn = 16'h1234;
        doRead (16'hFFFF, 16'h1234, 1'b0, "rd_io");
        ioIn = 16'h0000;

        // Unmapped read/write leave RAM alone and flag an error
        doWrite(16'h0000, 16'h7777, 1'b0, 1'b0, "wr_ram0");
        doRead (16'h0100, 16'h0000, 1'b1, "rd_unmapped");
        doWrite(16'h0100, 16'hDEAD, 1'b1, 1'b0, "wr_unmapped");
        doRead (16'h0000, 16'h7777, 1'b0, "rd_ram0_after_unmapped");

        // Simultaneous read and write: error, no side effects
        doWrite(16'h0003, 16'h1111, 1'b0, 1'b0, "wr_ram3");
        doRead (16'h0003, 16'h1111, 1'b0, "rd_ram3");
        @(negedge clk);
        memAddr = 16'h0003;
        memData = 16'h2222;
        memRd   = 1'b1;
        memWr   = 1'b1;
        @(posedge clk); #1;
        memRd = 1'b0;
        memWr = 1'b0;
        check("both_err", 32'(memErr), 32'd1);
        check("both_ready", 32'(memReady), 32'd1);
        check("both_dataout_held", 32'(memDataOut), 32'h1111);
        @(posedge clk); #1;
        check("both_err_pulse_end", 32'(memErr), 32'd0);
        doRead (16'h0003, 16'h1111, 1'b0, "rd_ram3_after_both");

        // Reset asserted while a read is stalled
        @(negedge clk);
        memAddr = 16'h0005;
        memRd   = 1'b1;
        @(posedge clk); #1;
        check("abort_stalled", 32'(memReady), 32'd0);
        rst = 1'b1;
        #1;
        memRd = 1'b0;
        check("abort_ready", 32'(memReady), 32'd1);
        check("abort_dataout", 32'(memDataOut), 32'd0);
        check("abort_ioout", 32'(ioOut), 32'd0);
        check("abort_iovalid", 32'(ioValid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Access counters (or unmapped addresses when counters are absent)
        doWrite(16'h0010, 16'hA001, 1'b0, 1'b0, "cnt_wr0");
        doWrite(16'h0011, 16'hA002, 1'b0, 1'b0, "cnt_wr1");
        doWrite(16'h0012, 16'hA003, 1'b0, 1'b0, "cnt_wr2");
        doRead (16'h0010, 16'hA001, 1'b0, "cnt_rd0");
        doRead (16'h0011, 16'hA002, 1'b0, "cnt_rd1");
`ifdef DMEM_ACCESS_CNT_EN
        doRead (16'hFFFD, 16'd3, 1'b0, "rd_wrcnt");
        doRead (16'hFFFE, 16'd3, 1'b0, "rd_rdcnt");
`else
        doRead (16'hFFFD, 16'd0, 1'b1, "rd_wrcnt_unmapped");
        doRead (16'hFFFE, 16'd0, 1'b1, "rd_rdcnt_unmapped");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
